// File: rtl/jk_register_bank_if.sv
// Control/data bundle for jk_register_bank: mode controls, load data,
// per-bit J/K inputs and the register outputs.
interface jk_register_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic             cnt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             tc;

  // The controlling side drives the modes and data, and observes the state.
  modport master (
    output en, load, cnt, d, J, K,
    input  Q, Qn, tc
  );

  // The register bank observes the modes and data, and drives the state.
  modport slave (
    input  en, load, cnt, d, J, K,
    output Q, Qn, tc
  );
endinterface

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops sharing clock, asynchronous active-low reset
// and enable. Modes in priority order: hold (en=0), parallel load,
// up-counter built from JK toggles, and per-bit JK.
module jk_register_bank #(
  parameter int          WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  jk_register_bank_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] carry;     // carry[i] = AND of q_reg[i-1:0]; bit 0 always toggles
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] jk_next;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi > 0) begin : g_carry
        assign carry[gi] = carry[gi-1] & q_reg[gi-1];
      end

      // In counter mode each bit is a JK flip-flop with J=K=carry, so the
      // external J/K are never looked at and cannot inject unknowns.
      assign j_eff[gi] = bus.cnt ? carry[gi] : bus.J[gi];
      assign k_eff[gi] = bus.cnt ? carry[gi] : bus.K[gi];

      // Classic JK characteristic: hold, reset, set, toggle.
      always_comb begin
        jk_next[gi] = q_reg[gi];
        unique case ({j_eff[gi], k_eff[gi]})
          2'b00:   jk_next[gi] = q_reg[gi];
          2'b01:   jk_next[gi] = 1'b0;
          2'b10:   jk_next[gi] = 1'b1;
          default: jk_next[gi] = ~q_reg[gi];
        endcase
      end
    end
  endgenerate

  // Mode priority: enable gates everything, then load beats counter/JK.
  always_comb begin
    q_next = q_reg;
    if (bus.en) begin
      if (bus.load) begin
        q_next = bus.d;
      end else begin
        q_next = jk_next;
      end
    end
  end

  // State register; reset is asynchronous and wins over any clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= RESET_Q;
    end else begin
      q_reg <= q_next;
    end
  end

  assign bus.Q  = q_reg;
  assign bus.Qn = ~q_reg;

  // Terminal count feeds the enable of a cascaded upper bank. It is held
  // low during reset so a cascade never sees a spurious carry.
  assign bus.tc = (&q_reg) & bus.cnt & bus.en & rst;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank. Stimulus pushes expected states into
// a scoreboard queue; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_jk_register_bank;

  typedef struct {
    string      name;
    int         which;   // 0: main 4-bit bank, 1: 8-bit cascade
    logic [7:0] q;
    logic [7:0] qn;
    logic       tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_c;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  jk_register_bank_if #(.WIDTH(4)) m_if ();
  jk_register_bank_if #(.WIDTH(4)) lo_if ();
  jk_register_bank_if #(.WIDTH(4)) hi_if ();

  jk_register_bank #(.WIDTH(4), .RESET_VAL(32'b1010)) u_main (
    .clk(clk), .rst(rst), .bus(m_if));
  jk_register_bank #(.WIDTH(4), .RESET_VAL(32'b1110)) u_lo (
    .clk(clk), .rst(rst_c), .bus(lo_if));
  jk_register_bank #(.WIDTH(4), .RESET_VAL(32'b0000)) u_hi (
    .clk(clk), .rst(rst_c), .bus(hi_if));

  assign hi_if.en = lo_if.tc;

  // Monitor: whenever an expectation is queued, sample the DUT and compare.
  initial begin
    exp_t       e;
    logic [7:0] aq;
    logic [7:0] aqn;
    logic       atc;
    forever begin
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.which == 0) begin
          aq  = {4'h0, m_if.Q};
          aqn = {4'h0, m_if.Qn};
          atc = m_if.tc;
        end else begin
          aq  = {hi_if.Q, lo_if.Q};
          aqn = {hi_if.Qn, lo_if.Qn};
          atc = hi_if.tc;
        end
        $display("t=%0t %s: Q=%b Qn=%b tc=%b", $time, e.name, aq, aqn, atc);
        n_checks++;
        if (aq !== e.q) begin
          n_fail++;
          $display("FAIL %s Q: got %b, expected %b", e.name, aq, e.q);
        end
        n_checks++;
        if (aqn !== e.qn) begin
          n_fail++;
          $display("FAIL %s Qn: got %b, expected %b", e.name, aqn, e.qn);
        end
        n_checks++;
        if (atc !== e.tc) begin
          n_fail++;
          $display("FAIL %s tc: got %b, expected %b", e.name, atc, e.tc);
        end
      end
    end
  end

  task automatic expect_state(input string name, input int which,
                              input logic [7:0] q, input logic tc);
    exp_t e;
    e.name  = name;
    e.which = which;
    e.q     = q;
    e.qn    = (which == 0) ? {4'h0, ~q[3:0]} : ~q;
    e.tc    = tc;
    exp_q.push_back(e);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s monitor timeout: pending %0d, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic en, input logic load, input logic cnt,
                       input logic [3:0] d, input logic [3:0] j, input logic [3:0] k);
    @(negedge clk);
    m_if.en   = en;
    m_if.load = load;
    m_if.cnt  = cnt;
    m_if.d    = d;
    m_if.J    = j;
    m_if.K    = k;
  endtask

  task automatic edge_check(input string name, input logic [3:0] q, input logic tc);
    @(posedge clk);
    #2;
    expect_state(name, 0, {4'h0, q}, tc);
  endtask

  task automatic cascade_check(input string name, input logic [7:0] q);
    @(posedge clk);
    #2;
    expect_state(name, 1, q, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    rst_c = 1'b0;
    m_if.en = 1'b1; m_if.load = 1'b1; m_if.cnt = 1'b0;
    m_if.d = 4'b0000; m_if.J = 4'b0000; m_if.K = 4'b0000;
    lo_if.en = 1'b1; lo_if.load = 1'b0; lo_if.cnt = 1'b1;
    lo_if.d = 4'b0000; lo_if.J = 4'b0000; lo_if.K = 4'b0000;
    hi_if.load = 1'b0; hi_if.cnt = 1'b1;
    hi_if.d = 4'b0000; hi_if.J = 4'b0000; hi_if.K = 4'b0000;

    // Known state, then asynchronous reset with no clock edge.
    edge_check("load_init", 4'b0000, 1'b0);
    #1 rst = 1'b0;
    #1 expect_state("rst_async", 0, 8'b0000_1010, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111);
    for (int i = 0; i < 3; i++) edge_check("rst_hold", 4'b1010, 1'b0);

    // JK truth table per bit.
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    edge_check("jk_clear", 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'bxxxx, 4'b1100, 4'b1010);
    edge_check("jk_edge1", 4'b1100, 1'b0);
    edge_check("jk_edge2", 4'b0100, 1'b0);

    // Counter with wrap-around and terminal count.
    drive(1'b1, 1'b1, 1'b0, 4'b1101, 4'b0000, 4'b0000);
    edge_check("cnt_load", 4'b1101, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'bxxxx, 4'bxxxx, 4'bxxxx);
    edge_check("cnt_1110", 4'b1110, 1'b0);
    edge_check("cnt_1111", 4'b1111, 1'b1);
    edge_check("cnt_wrap", 4'b0000, 1'b0);
    edge_check("cnt_0001", 4'b0001, 1'b0);

    // Priority: load over cnt, enable over load.
    drive(1'b1, 1'b1, 1'b0, 4'b0111, 4'b0000, 4'b0000);
    edge_check("pri_load", 4'b0111, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1111, 4'b1111);
    edge_check("pri_load_cnt", 4'b0011, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    edge_check("pri_en_hold", 4'b0011, 1'b0);

    // tc needs en: all ones held with en=0, then en=1 raises tc combinationally.
    drive(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000);
    edge_check("tc_load", 4'b1111, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    edge_check("tc_en_low", 4'b1111, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    #1 expect_state("tc_comb", 0, 8'b0000_1111, 1'b1);

    // Reset in the middle of counting.
    drive(1'b1, 1'b1, 1'b0, 4'b0101, 4'b0000, 4'b0000);
    edge_check("mid_load", 4'b0101, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    #2 rst = 1'b0;
    #1 expect_state("mid_rst", 0, 8'b0000_1010, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    edge_check("mid_1011", 4'b1011, 1'b0);
    edge_check("mid_1100", 4'b1100, 1'b0);

    // Two-bank cascade: upper enable driven by lower terminal count.
    expect_state("casc_rst", 1, 8'b0000_1110, 1'b0);
    @(negedge clk);
    rst_c = 1'b1;
    cascade_check("casc_e1", 8'b0000_1111);
    cascade_check("casc_e2", 8'b0001_0000);
    cascade_check("casc_e3", 8'b0001_0001);

    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
